// File: rtl/mc_main_control_pkg.sv
// Shared encodings for the multicycle RV32 main control: opcodes, FSM
// states, instruction classes and the datapath select encodings that the
// immediate extender, ALU decoder and datapath also rely on.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  // immSrc (extender encoding)
  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  // resultSrc
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // aluSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // aluSrcB
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // aluOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQTGT, S_BEQ, S_ILLEGAL
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD, C_STORE, C_RTYPE, C_ITYPE, C_BEQ, C_NONE
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [1:0] imm_src;
    logic       legal;
  } dec_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_main_control_if.sv
// Control bus between the main control FSM (master) and the datapath
// (slave): instruction fields and status in, enables and selects out.
interface mc_main_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic       regWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] immSrc;

  modport master (
    input  op, funct3, zero, mem_ready,
    output pcWrite, adrSrc, memWrite, irWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, aluOp, immSrc
  );

  modport slave (
    output op, funct3, zero, mem_ready,
    input  pcWrite, adrSrc, memWrite, irWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, aluOp, immSrc
  );
endinterface

// File: rtl/mc_main_control_op_decode.sv
// Combinational opcode decode: instruction class, extender immSrc and a
// legality flag. beq is the only branch supported, so funct3 matters there.
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  output dec_t       dec
);

  // Classify the opcode; anything unsupported stays C_NONE / IMM_NONE.
  always_comb begin
    dec = '{cls: C_NONE, imm_src: IMM_NONE, legal: 1'b0};
    case (op)
      OP_LOAD:   dec = '{cls: C_LOAD,  imm_src: IMM_I,    legal: 1'b1};
      OP_STORE:  dec = '{cls: C_STORE, imm_src: IMM_S,    legal: 1'b1};
      OP_RTYPE:  dec = '{cls: C_RTYPE, imm_src: IMM_NONE, legal: 1'b1};
      OP_ITYPE:  dec = '{cls: C_ITYPE, imm_src: IMM_I,    legal: 1'b1};
      OP_BRANCH: if (funct3 == F3_BEQ)
                   dec = '{cls: C_BEQ, imm_src: IMM_B,    legal: 1'b1};
      default:   ;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM of the multicycle RV32 core. Moore-decoded controls
// (FETCH/BEQ/MEMWRITE also look at mem_ready/zero), all outputs forced low
// while reset is high, and a wrapping retired-instruction counter.
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_main_control_if.master    bus,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t                state, state_nxt;
  dec_t                  dec;
  ctrl_t                 c, cg;
  logic                  retire;
  logic [INSTRET_W-1:0]  instret_q;

  mc_op_decode u_dec (
    .op     (bus.op),
    .funct3 (bus.funct3),
    .dec    (dec)
  );

  // Next-state and control decode from the current state.
  always_comb begin
    state_nxt = state;
    c         = '0;
    c.imm_src = dec.imm_src;
    case (state)
      S_FETCH: begin
        c.imm_src    = IMM_NONE;
        c.adr_src    = 1'b0;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALU;
        c.ir_write   = bus.mem_ready;
        c.pc_write   = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!dec.legal) state_nxt = S_ILLEGAL;
        else begin
          case (dec.cls)
            C_LOAD, C_STORE: state_nxt = S_MEMADR;
            C_RTYPE:         state_nxt = S_EXECUTER;
            C_ITYPE:         state_nxt = S_EXECUTEI;
            C_BEQ:           state_nxt = S_BEQTGT;
            default:         state_nxt = S_ILLEGAL;
          endcase
        end
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
        state_nxt   = (dec.cls == C_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
        if (bus.mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c.result_src = RES_MEM;
        c.reg_write  = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
        if (bus.mem_ready) state_nxt = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BEQTGT: begin
        // branch target goes through the ALU into ALUOut
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
        state_nxt   = S_BEQ;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.pc_write   = bus.zero;
        state_nxt    = S_FETCH;
      end
      S_ILLEGAL: begin
        c.imm_src = IMM_NONE;
        c.illegal = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // An instruction retires on the last cycle of its writeback/store/branch.
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && bus.mem_ready);

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      instret_q <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  // Reset gates every output so no strobe escapes mid-instruction.
  assign cg            = reset ? '0 : c;
  assign bus.pcWrite   = cg.pc_write;
  assign bus.adrSrc    = cg.adr_src;
  assign bus.memWrite  = cg.mem_write;
  assign bus.irWrite   = cg.ir_write;
  assign bus.regWrite  = cg.reg_write;
  assign bus.resultSrc = cg.result_src;
  assign bus.aluSrcA   = cg.alu_src_a;
  assign bus.aluSrcB   = cg.alu_src_b;
  assign bus.aluOp     = cg.alu_op;
  assign bus.immSrc    = cg.imm_src;
  assign illegal       = cg.illegal;
  assign instret       = reset ? '0 : instret_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: builds a per-cycle table of expected outputs
// from instruction-level timing rules (random waits, random branches) and
// replays it against the DUT, checking controls and instret every cycle.
module tb_mc_main_control;

  localparam int IW = 4;  // small counter so wrap-around is exercised

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          illegal;
  logic [IW-1:0] instret;

  mc_main_control_if bus ();

  mc_main_control #(.INSTRET_W(IW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .illegal (illegal),
    .instret (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        z;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [15:0] exp;
    logic        ret;
  } rec_t;

  rec_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   cnt = 0;

  // {pcWrite,adrSrc,memWrite,irWrite,regWrite,resultSrc,aluSrcA,aluSrcB,aluOp,immSrc,illegal}
  function automatic logic [15:0] o(input logic pc, adr, mw, ir, rw,
                                    input logic [1:0] rs, sa, sb, ao, imm,
                                    input logic ill);
    return {pc, adr, mw, ir, rw, rs, sa, sb, ao, imm, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, rdy, z, input logic [6:0] op,
                      input logic [2:0] f3, input logic [15:0] e, input logic ret);
    rec_t r;
    r.rst = rst; r.rdy = rdy; r.z = z; r.op = op; r.f3 = f3; r.exp = e; r.ret = ret;
    q.push_back(r);
  endtask

  task automatic push_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b1, rb(), rb(), 7'h00, 3'h0, 16'h0, 1'b0);
  endtask

  task automatic push_fetch(input logic [6:0] op, input logic [2:0] f3, input int fw);
    for (int i = 0; i < fw; i++)
      push(1'b0, 1'b0, rb(), op, f3, o(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b11, 0), 1'b0);
    push(1'b0, 1'b1, rb(), op, f3, o(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b11, 0), 1'b0);
  endtask

  // k: 0=lw 1=sw 2=R 3=I 4=beq. fw/mw: wait cycles in fetch/memory.
  // rst_mem: assert reset on the first store cycle instead of completing.
  task automatic add_instr(input int k, input int fw, input int mw, input logic z,
                           input logic [2:0] f3, input logic rst_mem);
    logic [6:0] op;
    logic [1:0] imm;
    case (k)
      0: begin op = 7'b0000011; imm = 2'b00; end
      1: begin op = 7'b0100011; imm = 2'b01; end
      2: begin op = 7'b0110011; imm = 2'b11; end
      3: begin op = 7'b0010011; imm = 2'b00; end
      default: begin op = 7'b1100011; imm = 2'b10; end
    endcase
    push_fetch(op, f3, fw);
    push(1'b0, rb(), rb(), op, f3, o(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,imm, 0), 1'b0);
    case (k)
      0: begin
        push(1'b0, rb(), rb(), op, f3, o(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,imm, 0), 1'b0);
        for (int i = 0; i < mw; i++)
          push(1'b0, 1'b0, rb(), op, f3, o(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,imm, 0), 1'b0);
        push(1'b0, 1'b1, rb(), op, f3, o(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,imm, 0), 1'b0);
        push(1'b0, rb(), rb(), op, f3, o(0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,imm, 0), 1'b1);
      end
      1: begin
        push(1'b0, rb(), rb(), op, f3, o(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,imm, 0), 1'b0);
        if (rst_mem) push(1'b1, 1'b0, rb(), op, f3, 16'h0, 1'b0);
        else begin
          for (int i = 0; i < mw; i++)
            push(1'b0, 1'b0, rb(), op, f3, o(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,imm, 0), 1'b0);
          push(1'b0, 1'b1, rb(), op, f3, o(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,imm, 0), 1'b1);
        end
      end
      2, 3: begin
        push(1'b0, rb(), rb(), op, f3,
             o(0,0,0,0,0, 2'b00,2'b10,(k == 3) ? 2'b01 : 2'b00,2'b10,imm, 0), 1'b0);
        push(1'b0, rb(), rb(), op, f3, o(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,imm, 0), 1'b1);
      end
      default: begin
        push(1'b0, rb(), rb(), op, f3, o(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,imm, 0), 1'b0);
        push(1'b0, rb(), z, op, f3, o(z,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,imm, 0), 1'b1);
      end
    endcase
  endtask

  // Unsupported instruction: fetch, decode, then stuck with only illegal set.
  task automatic add_illegal(input logic [6:0] op, input logic [2:0] f3, input int n);
    push_fetch(op, f3, 0);
    push(1'b0, rb(), rb(), op, f3, o(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b11, 0), 1'b0);
    for (int i = 0; i < n; i++)
      push(1'b0, rb(), rb(), op, f3, o(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b11, 1), 1'b0);
  endtask

  initial begin
    logic [15:0]   obs;
    logic [IW-1:0] exp_i;
    int            k;

    bus.op = '0; bus.funct3 = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    push_reset(2);
    add_instr(3, 0, 0, 1'b0, 3'b000, 1'b0);          // addi, no waits
    add_instr(0, 0, 2, 1'b0, 3'b010, 1'b0);          // lw, 2 memory waits
    add_instr(1, 0, 1, 1'b0, 3'b010, 1'b0);          // sw, 1 memory wait
    add_instr(4, 0, 0, 1'b1, 3'b000, 1'b0);          // beq taken
    add_instr(4, 1, 0, 1'b0, 3'b000, 1'b0);          // beq not taken, fetch wait
    repeat (30) begin
      k = $urandom_range(0, 4);
      add_instr(k, $urandom_range(0, 2), $urandom_range(0, 2), rb(),
                (k == 4) ? 3'b000 : 3'($urandom_range(0, 7)), 1'b0);
    end
    add_instr(1, 0, 2, 1'b0, 3'b010, 1'b1);          // reset lands in store cycle
    add_instr(2, 0, 0, 1'b0, 3'b000, 1'b0);
    add_illegal(7'b1101111, 3'b000, 4);              // jal: unsupported
    push_reset(1);
    add_instr(3, 0, 0, 1'b0, 3'b001, 1'b0);
    add_illegal(7'b1100011, 3'b001, 3);              // bne: unsupported
    push_reset(2);
    add_instr(0, 0, 0, 1'b0, 3'b010, 1'b0);

    foreach (q[i]) begin
      @(negedge clk);
      reset         = q[i].rst;
      bus.op        = q[i].op;
      bus.funct3    = q[i].f3;
      bus.zero      = q[i].z;
      bus.mem_ready = q[i].rdy;
      #1;
      obs = {bus.pcWrite, bus.adrSrc, bus.memWrite, bus.irWrite, bus.regWrite,
             bus.resultSrc, bus.aluSrcA, bus.aluSrcB, bus.aluOp, bus.immSrc, illegal};
      checks++;
      assert (obs === q[i].exp) else begin
        errs++;
        $error("FAIL outs step=%0d got=%h exp=%h", i, obs, q[i].exp);
      end
      exp_i = q[i].rst ? '0 : IW'(cnt);
      checks++;
      assert (instret === exp_i) else begin
        errs++;
        $error("FAIL instret step=%0d got=%0d exp=%0d", i, instret, exp_i);
      end
      if (q[i].rst) cnt = 0;
      else if (q[i].ret) cnt = (cnt + 1) % (1 << IW);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
